// File: rtl/dsp_pkg.sv
// Purpose: shared types and constants for the dsp coefficient-memory arbiter.
// Latency: n/a (package only).
// Backpressure: n/a.
package dsp_pkg;

    // Arbiter FSM encoding: waiting for requests, or a requester owns the port.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_t;

    // Default coefficient memory geometry behind the dsp datapath.
    localparam int DSP_AW = 6;
    localparam int DSP_DW = 14;

    // Burst length bounds; the beat counter is sized for the largest legal cap.
    localparam int DSP_MAX_BURST_DEF   = 8;
    localparam int DSP_MAX_BURST_LIMIT = 15;
    localparam int BEAT_CNT_W          = $clog2(DSP_MAX_BURST_LIMIT + 1);

endpackage

// File: rtl/dsp_rr_pick.sv
// Purpose: rotate-priority picker, first set request at or after ptr (cyclic) wins.
// Latency: purely combinational.
// Backpressure: none; win is all-zero when no request is set.
module dsp_rr_pick #(
    parameter int NREQ = 2,
    parameter int PW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] win
);

    logic found;

    // Walk candidates in order ptr, ptr+1, ... and keep the first requester found.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && req[i] && (i == ((int'(ptr) + k) % NREQ))) begin
                    win[i] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/dsp_mem_arb.sv
// Purpose: round-robin burst arbiter sharing one single-port coefficient memory; option DSP_MEM_ARB_PRIO_EN.
// Latency: grant 1 cycle after request; mem access 1 cycle after beat; read return RD_LAT after mem_en.
// Backpressure: requesters wait with req held while gnt is low; a 1-cycle gnt gap separates bursts.
module dsp_mem_arb
    import dsp_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int AW        = DSP_AW,
    parameter int DW        = DSP_DW,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = DSP_MAX_BURST_DEF
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      we,
    input  logic [NREQ-1:0]      last,
    input  logic [NREQ*AW-1:0]   addr,
    input  logic [NREQ*DW-1:0]   wdata,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      rvalid,
    output logic [DW-1:0]        rdata,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wdata,
    input  logic [DW-1:0]        mem_rdata
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t              state;
    arb_state_t              state_nxt;
    logic [NREQ-1:0]         gnt_nxt;
    logic [IW-1:0]           ptr;
    logic [IW-1:0]           ptr_nxt;
    logic [IW-1:0]           ptr_after;
    logic [BEAT_CNT_W-1:0]   cnt;
    logic [BEAT_CNT_W-1:0]   cnt_nxt;
    logic [BEAT_CNT_W-1:0]   cnt_inc;

    logic [NREQ-1:0]         rr_req;
    logic [NREQ-1:0]         rr_win;
    logic [NREQ-1:0]         idle_win;
    logic                    preempt;

    logic                    beat;
    logic                    sel_we;
    logic                    sel_last;
    logic [AW-1:0]           sel_addr;
    logic [DW-1:0]           sel_wdata;

    // One-hot owner tag per in-flight read; stage 0 lines up with mem_en.
    logic [NREQ-1:0]         tag_pipe [RD_LAT];

    // Steer the owner's beat fields through the one-hot grant and derive the next rr pointer.
    always_comb begin
        sel_we    = 1'b0;
        sel_last  = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        ptr_after = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_we    = we[i];
                sel_last  = last[i];
                sel_addr  = addr[i*AW +: AW];
                sel_wdata = wdata[i*DW +: DW];
                ptr_after = (i == NREQ - 1) ? '0 : IW'(i + 1);
            end
        end
    end

    // A beat is any owning cycle where the granted requester still holds req.
    assign beat    = (state == ST_OWN) && (|(req & gnt));
    assign cnt_inc = cnt + BEAT_CNT_W'(1);

`ifdef DSP_MEM_ARB_PRIO_EN
    // Requester 0 jumps the queue in IDLE and can cut another owner's burst after a beat.
    assign rr_req   = req & ~NREQ'(1);
    assign idle_win = req[0] ? NREQ'(1) : rr_win;
    assign preempt  = req[0] & ~gnt[0];
`else
    // Plain round-robin across all requesters, bursts never cut short.
    assign rr_req   = req;
    assign idle_win = rr_win;
    assign preempt  = 1'b0;
`endif

    dsp_rr_pick #(
        .NREQ (NREQ),
        .PW   (IW)
    ) u_pick (
        .req  (rr_req),
        .ptr  (ptr),
        .win  (rr_win)
    );

    // Next-state logic: grant a winner from IDLE, release on last/cap/drop/preempt.
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        if (state == ST_IDLE) begin
            if (|req) begin
                state_nxt = ST_OWN;
                gnt_nxt   = idle_win;
                cnt_nxt   = '0;
            end
        end else begin
            if (beat) begin
                cnt_nxt = cnt_inc;
            end
            // Returning through IDLE guarantees a gnt-low cycle between bursts.
            if (!beat || sel_last || (cnt_inc == BEAT_CNT_W'(MAX_BURST)) || preempt) begin
                state_nxt = ST_IDLE;
                gnt_nxt   = '0;
                ptr_nxt   = ptr_after;
            end
        end
    end

    // Arbiter state, grant, rr pointer and beat counter registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
            gnt   <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Registered memory port: each beat becomes one access on the following cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_en <= beat;
            mem_we <= beat & sel_we;
            if (beat) begin
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
            end
        end
    end

    // Carry the reader's identity alongside the memory latency so returns survive grant changes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < RD_LAT; k++) begin
                tag_pipe[k] <= '0;
            end
            rvalid <= '0;
        end else begin
            tag_pipe[0] <= (beat && !sel_we) ? gnt : '0;
            for (int k = 1; k < RD_LAT; k++) begin
                tag_pipe[k] <= tag_pipe[k-1];
            end
            rvalid <= tag_pipe[RD_LAT-1];
        end
    end

    // The macro's output register already holds the data; gate it with the registered strobe.
    assign rdata = (|rvalid) ? mem_rdata : '0;

endmodule

// File: tb/tb_dsp_mem_arb.sv
// Purpose: randomized self-checking bench for dsp_mem_arb against a cycle-level reference model.
// Latency: model predicts grant, memory access and tagged read return per cycle.
// Backpressure: requester agents hold req until their planned beats are granted.
module tb_dsp_mem_arb;

    localparam int NREQ      = 2;
    localparam int AW        = 6;
    localparam int DW        = 14;
    localparam int RD_LAT    = 2;
    localparam int MAX_BURST = 8;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic [NREQ-1:0]      req, we, last, gnt, rvalid;
    logic [NREQ*AW-1:0]   addr;
    logic [NREQ*DW-1:0]   wdata;
    logic [DW-1:0]        rdata, mem_wdata, mem_rdata;
    logic                 mem_en, mem_we;
    logic [AW-1:0]        mem_addr;

    always #5 clk = ~clk;

    dsp_mem_arb #(
        .NREQ(NREQ), .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .rstn(rstn), .req(req), .we(we), .last(last), .addr(addr),
        .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_en(mem_en),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Memory macro: synchronous write, read data out RD_LAT cycles after mem_en.
    logic [DW-1:0] init_mem [64];
    logic [DW-1:0] mem      [64];
    logic [DW-1:0] rd_pipe  [RD_LAT];
    bit            fill = 1'b1;

    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_mem[i];
        end else if (mem_en && mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        rd_pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr] : DW'($urandom);
        for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign mem_rdata = rd_pipe[RD_LAT-1];

    // Counters and checker.
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Requester agents: a plan of beats per requester.
    int            blen   [NREQ];
    bit            nolast [NREQ];
    bit            pwe    [NREQ];
    logic [AW-1:0] paddr  [NREQ];
    logic [DW-1:0] pdat   [NREQ];
    bit            c_req  [NREQ];
    bit            c_we   [NREQ];
    bit            c_last [NREQ];

    // Reference model state.
    typedef struct {
        int            due;
        int            id;
        logic [DW-1:0] data;
    } ret_t;

    ret_t            rq[$];
    logic [DW-1:0]   m_mem [64];
    logic [NREQ-1:0] e_gnt = '0;
    bit              e_en = 1'b0;
    bit              e_we = 1'b0;
    logic [AW-1:0]   e_addr = '0;
    logic [DW-1:0]   e_wdata = '0;
    int              m_ptr = 0;
    int              m_beats = 0;
    int              cyc = 0;
    bit              lw_vld = 1'b0;
    logic [AW-1:0]   lw_addr = '0;
    logic [DW-1:0]   lw_old = '0;

    task automatic set_plan(input int i, input int len, input bit w, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input bit nl);
        blen[i]   = len;
        pwe[i]    = w;
        paddr[i]  = a;
        pdat[i]   = d;
        nolast[i] = nl;
    endtask

    // First requesting index scanning cyclically from the rr pointer, -1 if none.
    function automatic int rr_pick(input bit skip0);
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (m_ptr + k) % NREQ;
            if (c_req[j] && !(skip0 && j == 0)) return j;
        end
        return -1;
    endfunction

    task automatic compare_outputs();
        logic [NREQ-1:0] erv;
        logic [DW-1:0]   erd;
        erv = '0;
        erd = '0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            erv = NREQ'(1) << rq[0].id;
            erd = rq[0].data;
            void'(rq.pop_front());
        end
        chk("gnt", 32'(gnt), 32'(e_gnt));
        chk("mem_en", 32'(mem_en), 32'(e_en));
        if (e_en) begin
            chk("mem_we", 32'(mem_we), 32'(e_we));
            chk("mem_addr", 32'(mem_addr), 32'(e_addr));
            chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
        end
        chk("rvalid", 32'(rvalid), 32'(erv));
        if (erv != '0) chk("rdata", 32'(rdata), 32'(erd));
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NREQ; i++) begin
            c_req[i]  = (blen[i] > 0);
            c_last[i] = (blen[i] == 1) && !nolast[i];
            c_we[i]   = pwe[i];
            req[i]    = c_req[i];
            last[i]   = c_last[i];
            we[i]     = c_we[i];
            addr[i*AW +: AW]  = paddr[i];
            wdata[i*DW +: DW] = pdat[i];
        end
    endtask

    // One cycle of arbitration rules: returns the outputs expected after the next clock edge.
    task automatic model_step();
        logic [NREQ-1:0] g;
        int              o;
        int              w;
        bit              rel;
        g      = e_gnt;
        e_en   = 1'b0;
        lw_vld = 1'b0;
        if (g == '0) begin
`ifdef DSP_MEM_ARB_PRIO_EN
            w = c_req[0] ? 0 : rr_pick(1'b1);
`else
            w = rr_pick(1'b0);
`endif
            if (w >= 0) e_gnt = NREQ'(1) << w;
            m_beats = 0;
        end else begin
            o = 0;
            for (int i = 0; i < NREQ; i++) if (g[i]) o = i;
            rel = 1'b1;
            if (c_req[o]) begin
                e_en    = 1'b1;
                e_we    = c_we[o];
                e_addr  = paddr[o];
                e_wdata = pdat[o];
                m_beats++;
                if (c_we[o]) begin
                    lw_vld  = 1'b1;
                    lw_addr = paddr[o];
                    lw_old  = m_mem[paddr[o]];
                    m_mem[paddr[o]] = pdat[o];
                end else begin
                    rq.push_back('{due: cyc + 1 + RD_LAT, id: o, data: m_mem[paddr[o]]});
                end
                rel = c_last[o] || (m_beats == MAX_BURST);
`ifdef DSP_MEM_ARB_PRIO_EN
                rel = rel || (o != 0 && c_req[0]);
`endif
            end
            if (rel) begin
                e_gnt = '0;
                m_ptr = (o + 1) % NREQ;
            end
        end
        // Agents consume a planned beat whenever their request met a grant.
        for (int i = 0; i < NREQ; i++) begin
            if (c_req[i] && g[i]) begin
                blen[i]--;
                paddr[i] = paddr[i] + AW'(1);
                pdat[i]  = DW'($urandom);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_outputs();
        drive_inputs();
        model_step();
        cyc++;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic check_reset_values(input string pfx);
        chk({pfx, "_gnt"}, 32'(gnt), 32'd0);
        chk({pfx, "_rvalid"}, 32'(rvalid), 32'd0);
        chk({pfx, "_rdata"}, 32'(rdata), 32'd0);
        chk({pfx, "_mem_en"}, 32'(mem_en), 32'd0);
        chk({pfx, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({pfx, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({pfx, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    endtask

    // Asynchronous reset in the middle of traffic; the access queued for this cycle is lost.
    task automatic do_reset(input int hold);
        @(negedge clk);
        compare_outputs();
        rstn = 1'b0;
        for (int i = 0; i < NREQ; i++) blen[i] = 0;
        drive_inputs();
        #1;
        check_reset_values("rst");
        if (lw_vld) m_mem[lw_addr] = lw_old;
        lw_vld  = 1'b0;
        rq.delete();
        e_gnt   = '0;
        e_en    = 1'b0;
        m_ptr   = 0;
        m_beats = 0;
        cyc++;
        repeat (hold) @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            init_mem[i] = DW'($urandom);
            m_mem[i]    = init_mem[i];
        end
        for (int i = 0; i < NREQ; i++) set_plan(i, 0, 1'b0, '0, '0, 1'b0);
        drive_inputs();
        repeat (3) @(negedge clk);
        check_reset_values("init");
        fill = 1'b0;
        rstn = 1'b1;

        // First request after reset: requester 1 alone.
        set_plan(1, 2, 1'b0, 6'h10, '0, 1'b0);
        run(6);
        // Contention from IDLE with pointer back at 0: 3-beat burst for 0, gap, then 1.
        set_plan(0, 3, 1'b0, 6'h00, '0, 1'b0);
        set_plan(1, 2, 1'b0, 6'h20, '0, 1'b0);
        run(12);
        // Burst cap: requester 0 never marks last, then drops req mid-burst.
        set_plan(0, 30, 1'b1, 6'h30, 14'h0155, 1'b1);
        run(14);
        blen[0] = 0;
        run(4);
        // Read tagging across a grant change.
        set_plan(0, 1, 1'b0, 6'h05, '0, 1'b0);
        tick();
        set_plan(1, 1, 1'b0, 6'h3F, '0, 1'b0);
        run(8);
        // Write then read back the same word.
        set_plan(1, 1, 1'b1, 6'h11, 14'h2A5A, 1'b0);
        run(4);
        set_plan(0, 1, 1'b0, 6'h11, '0, 1'b0);
        run(6);
        // Requester 0 arrives while requester 1 owns a burst.
        set_plan(1, 6, 1'b0, 6'h08, '0, 1'b0);
        run(3);
        set_plan(0, 2, 1'b0, 6'h18, '0, 1'b0);
        run(14);
        // Reset in the middle of a write burst.
        set_plan(0, 6, 1'b1, 6'h22, 14'h1234, 1'b0);
        run(3);
        do_reset(2);
        run(3);

        // Random traffic with occasional cancels and resets.
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (blen[i] == 0 && $urandom_range(3) == 0) begin
                    set_plan(i, int'($urandom_range(12, 1)), 1'($urandom_range(1)),
                             AW'($urandom), DW'($urandom), ($urandom_range(7) == 0));
                end else if (blen[i] > 0 && $urandom_range(39) == 0) begin
                    blen[i] = 0;
                end
            end
            if ($urandom_range(299) == 0) do_reset(1);
            else tick();
        end
        for (int i = 0; i < NREQ; i++) blen[i] = 0;
        run(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
